// File: rtl/mips_cpu_control_fsm.sv
// Multi-cycle control FSM for the bus-based MIPS core: FETCH/DECODE/EXEC/MEM/WB sequencing, halt and illegal-opcode detection.
// Latency (no stalls): ALU op 4, lw 5, sw 4, branch/jump 3 (4 with link), mult/div 2+MULDIV_LATENCY cycles.
// Backpressure: waitrequest holds the current FETCH or MEM access; it is ignored in every other state.
//
// Optional feature macro: MIPS_CTRL_MULDIV_EN enables mult/multu/div/divu/mthi/mtlo/mfhi/mflo.
// Without it those funct codes are illegal and hilo_write stays 0.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   opcode/funct        IR[31:26] / IR[5:0]; branch_type = IR[20:16] (REGIMM selector)
//   waitrequest         memory stall; target_is_zero = datapath next-PC is 0 (halt request)
//   active, illegal     running flag (low in HALT); sticky undecodable-instruction flag
//   mem_read/mem_write/addr_sel/ir_write/pc_write   memory port and PC/IR control
//   regdst/alusrc/aluop/branch/jump/link/memtoreg/reg_write/hilo_write   datapath control
module mips_cpu_control_fsm #(
  parameter int ALUOP_WIDTH    = 4,
  parameter int MULDIV_LATENCY = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [5:0]             opcode,
  input  logic [5:0]             funct,
  input  logic [4:0]             branch_type,
  input  logic                   waitrequest,
  input  logic                   target_is_zero,
  output logic                   active,
  output logic                   illegal,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   addr_sel,
  output logic                   ir_write,
  output logic                   pc_write,
  output logic [1:0]             regdst,
  output logic                   alusrc,
  output logic [ALUOP_WIDTH-1:0] aluop,
  output logic                   branch,
  output logic                   jump,
  output logic                   link,
  output logic                   memtoreg,
  output logic                   reg_write,
  output logic                   hilo_write
);

  if (ALUOP_WIDTH < 4 || MULDIV_LATENCY < 1) begin : g_bad_params
    $error("mips_cpu_control_fsm: ALUOP_WIDTH must be >= 4 and MULDIV_LATENCY >= 1");
  end

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ADDIU  = 6'b001001;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;

  localparam logic [5:0] FN_JR     = 6'b001000;
  localparam logic [5:0] FN_JALR   = 6'b001001;
  localparam logic [5:0] FN_MFHI   = 6'b010000;
  localparam logic [5:0] FN_MTHI   = 6'b010001;
  localparam logic [5:0] FN_MFLO   = 6'b010010;
  localparam logic [5:0] FN_MTLO   = 6'b010011;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  state_t state, state_n;

  // Instruction decode, valid from DECODE onwards while the IR is stable.
  logic       dec_legal;
  logic [3:0] dec_aluop;
  logic       dec_alusrc;
  logic       dec_branch;
  logic       dec_jump;
  logic       dec_link;
  logic       dec_load;
  logic       dec_store;
  logic       dec_writes;   // instruction needs the WB state
  logic [1:0] dec_regdst;
`ifdef MIPS_CTRL_MULDIV_EN
  logic       dec_muldiv;
  logic       dec_hlmove;
`endif

  always_comb begin
    dec_legal  = 1'b1;
    dec_aluop  = 4'b0000;
    dec_alusrc = 1'b0;
    dec_branch = 1'b0;
    dec_jump   = 1'b0;
    dec_link   = 1'b0;
    dec_load   = 1'b0;
    dec_store  = 1'b0;
    dec_writes = 1'b0;
    dec_regdst = 2'b00;
`ifdef MIPS_CTRL_MULDIV_EN
    dec_muldiv = 1'b0;
    dec_hlmove = 1'b0;
`endif
    case (opcode)
      OP_RTYPE: begin
        dec_regdst = 2'b01;
        if (funct == FN_JR) begin
          dec_jump = 1'b1;
        end else if (funct == FN_JALR) begin
          dec_jump   = 1'b1;
          dec_link   = 1'b1;
          dec_writes = 1'b1;
        end
`ifdef MIPS_CTRL_MULDIV_EN
        else if (funct[5:2] == 4'b0110) begin
          dec_muldiv = 1'b1;
        end else if (funct == FN_MTHI || funct == FN_MTLO) begin
          dec_hlmove = 1'b1;
        end
`else
        else if (funct[5:2] == 4'b0110 || funct == FN_MTHI || funct == FN_MTLO ||
                 funct == FN_MFHI || funct == FN_MFLO) begin
          dec_legal = 1'b0;
        end
`endif
        else begin
          dec_writes = 1'b1;
        end
      end
      OP_ADDIU: begin
        dec_aluop  = 4'b0001;
        dec_alusrc = 1'b1;
        dec_writes = 1'b1;
      end
      OP_ANDI: begin
        dec_aluop  = 4'b0010;
        dec_alusrc = 1'b1;
        dec_writes = 1'b1;
      end
      OP_BEQ: begin
        dec_aluop  = 4'b0011;
        dec_branch = 1'b1;
      end
      OP_BNE: begin
        dec_aluop  = 4'b1000;
        dec_branch = 1'b1;
      end
      OP_BGTZ: begin
        dec_aluop  = 4'b0100;
        dec_branch = 1'b1;
      end
      OP_BLEZ: begin
        dec_aluop  = 4'b0111;
        dec_branch = 1'b1;
      end
      OP_REGIMM: begin
        // bit0 picks ge0 vs lt0, bit4 picks the linking variants.
        if (branch_type == 5'b00000 || branch_type == 5'b00001 ||
            branch_type == 5'b10000 || branch_type == 5'b10001) begin
          dec_aluop  = branch_type[0] ? 4'b0101 : 4'b0110;
          dec_branch = 1'b1;
          dec_link   = branch_type[4];
          dec_writes = branch_type[4];
          dec_regdst = 2'b10;
        end else begin
          dec_legal = 1'b0;
        end
      end
      OP_LW: begin
        dec_aluop  = 4'b0001;
        dec_alusrc = 1'b1;
        dec_load   = 1'b1;
        dec_writes = 1'b1;
      end
      OP_SW: begin
        dec_aluop  = 4'b0001;
        dec_alusrc = 1'b1;
        dec_store  = 1'b1;
      end
      OP_J: begin
        dec_jump = 1'b1;
      end
      OP_JAL: begin
        dec_jump   = 1'b1;
        dec_link   = 1'b1;
        dec_writes = 1'b1;
        dec_regdst = 2'b10;
      end
      default: begin
        dec_legal = 1'b0;
      end
    endcase
  end

`ifdef MIPS_CTRL_MULDIV_EN
  // Counts EXEC cycles of a mult/div; idles at 0 so every operation starts fresh.
  localparam int CW = (MULDIV_LATENCY > 1) ? $clog2(MULDIV_LATENCY) : 1;
  logic [CW-1:0] md_cnt;
  logic          md_last;

  assign md_last = (md_cnt == CW'(MULDIV_LATENCY - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt <= '0;
    end else if (state == S_EXEC && dec_muldiv && !md_last) begin
      md_cnt <= md_cnt + 1'b1;
    end else begin
      md_cnt <= '0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      illegal <= 1'b0;
    end else begin
      state <= state_n;
      if (state == S_DECODE && !dec_legal) begin
        illegal <= 1'b1;
      end
    end
  end

  always_comb begin
    state_n    = state;
    active     = 1'b1;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    addr_sel   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    regdst     = 2'b00;
    alusrc     = 1'b0;
    aluop      = '0;
    branch     = 1'b0;
    jump       = 1'b0;
    link       = 1'b0;
    memtoreg   = 1'b0;
    reg_write  = 1'b0;
    hilo_write = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read = 1'b1;
        if (!waitrequest) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_n  = S_DECODE;
        end
      end
      S_DECODE: begin
        state_n = dec_legal ? S_EXEC : S_HALT;
      end
      S_EXEC: begin
        aluop    = ALUOP_WIDTH'(dec_aluop);
        alusrc   = dec_alusrc;
        branch   = dec_branch;
        jump     = dec_jump;
        pc_write = dec_branch | dec_jump;
        if (dec_load || dec_store) begin
          state_n = S_MEM;
        end else if (dec_writes) begin
          state_n = S_WB;
        end else if (dec_jump && target_is_zero) begin
          state_n = S_HALT;
        end else begin
          state_n = S_FETCH;
        end
`ifdef MIPS_CTRL_MULDIV_EN
        if (dec_hlmove) begin
          hilo_write = 1'b1;
        end
        if (dec_muldiv) begin
          hilo_write = md_last;
          if (!md_last) begin
            state_n = S_EXEC;
          end
        end
`endif
      end
      S_MEM: begin
        // ALU result is the address, so keep the ALU controls steady.
        aluop     = ALUOP_WIDTH'(dec_aluop);
        alusrc    = dec_alusrc;
        addr_sel  = 1'b1;
        mem_read  = dec_load;
        mem_write = dec_store;
        if (!waitrequest) begin
          state_n = dec_load ? S_WB : S_FETCH;
        end
      end
      S_WB: begin
        aluop     = ALUOP_WIDTH'(dec_aluop);
        alusrc    = dec_alusrc;
        reg_write = 1'b1;
        regdst    = dec_regdst;
        memtoreg  = dec_load;
        link      = dec_link;
        // Only jumps halt; linking branches pass through here but never halt.
        state_n   = (dec_jump && target_is_zero) ? S_HALT : S_FETCH;
      end
      S_HALT: begin
        active = 1'b0;
      end
      default: begin
        state_n = S_FETCH;
      end
    endcase
  end

endmodule
